ball_game_sequencer: RTL and testbench

- Round-level controller for the ballplayer game; runs on the divided physics tick clk_out (about 18.2 ms).
- Serves the ball by driving the release/hold input of the bouncing-ball physics block, holding it at the home position when needed.
- Scores hand hits, tracks lives and a countdown round timer, and lowers the bounce coefficient k as the score rises.
- Drives over_flag and end-of-game beep request to the physics, beeper and LCD blocks.

---
 rtl/ball_game_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_ball_game_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ball_game_sequencer.sv
// Round controller for the ballplayer game: serves the ball, scores hand hits,
// tracks lives and the round timer, and raises difficulty by lowering k.
module ball_game_sequencer #(
    parameter logic [8:0]  HOME_Y        = 9'd20,
    parameter logic [1:0]  K_INIT        = 2'd3,
    parameter int unsigned LEVEL_STEP    = 10,
    parameter logic [1:0]  LIVES_INIT    = 2'd3,
    parameter logic [6:0]  ROUND_SEC     = 7'd60,
    parameter int unsigned TICKS_PER_SEC = 55,
    parameter int unsigned ARM_TICKS     = 3,
    parameter logic [13:0] SCORE_MAX     = 14'd9999
) (
    input  logic        clk_out,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        stop_flag,
    input  logic [8:0]  pic_y,
    input  logic [8:0]  handline,
    output logic        release_n,
    output logic [8:0]  home,
    output logic [1:0]  k,
    output logic        over_flag,
    output logic        end_beep,
    output logic [13:0] score,
    output logic [1:0]  lives,
    output logic [6:0]  time_left,
    output logic [2:0]  state
);

    localparam int unsigned SEC_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned LVL_W = (LEVEL_STEP > 2) ? $clog2(LEVEL_STEP) : 1;
    localparam int unsigned ARM_W = ($clog2(ARM_TICKS) > 2) ? $clog2(ARM_TICKS) : 2;

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(TICKS_PER_SEC - 1);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LEVEL_STEP - 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_PLAY   = 3'd2,
        S_LANDED = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             release_n_q, release_n_d;
    logic [1:0]       k_q, k_d;
    logic             over_flag_q, over_flag_d;
    logic             end_beep_q, end_beep_d;
    logic [13:0]      score_q, score_d;
    logic [1:0]       lives_q, lives_d;
    logic [6:0]       time_left_q, time_left_d;
    logic [SEC_W-1:0] sec_div_q, sec_div_d;
    logic [LVL_W-1:0] level_cnt_q, level_cnt_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic             btn_q, btn_d;
    logic             above_q, above_d;

    logic start_pe_c;
    logic above_c;
    logic hit_c;
    logic wrap_c;
    logic init_c;

    always_comb begin
        start_pe_c  = start_btn & ~btn_q;
        above_c     = (pic_y < handline);
        hit_c       = 1'b0;
        wrap_c      = 1'b0;
        init_c      = 1'b0;

        state_d     = state_q;
        k_d         = k_q;
        score_d     = score_q;
        lives_d     = lives_q;
        time_left_d = time_left_q;
        sec_div_d   = sec_div_q;
        level_cnt_d = level_cnt_q;
        arm_cnt_d   = arm_cnt_q;
        above_d     = above_q;
        btn_d       = start_btn;

        case (state_q)
            S_IDLE: begin
                if (start_pe_c) begin
                    init_c  = 1'b1;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                above_d = above_c;
                if (arm_cnt_q == ARM_LAST) begin
                    arm_cnt_d = '0;
                    state_d   = S_PLAY;
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            S_PLAY: begin
                above_d = above_c;
                hit_c   = above_c & ~above_q;
                wrap_c  = (sec_div_q == SEC_LAST);
                sec_div_d = wrap_c ? '0 : sec_div_q + SEC_W'(1);
                if (wrap_c && time_left_q != 7'd0) begin
                    time_left_d = time_left_q - 7'd1;
                end
                // A hit is scored even when the round ends on the same tick.
                if (hit_c) begin
                    if (score_q < SCORE_MAX) begin
                        score_d = score_q + 14'd1;
                    end
                    if (level_cnt_q == LVL_LAST) begin
                        level_cnt_d = '0;
                        if (k_q != 2'd0) begin
                            k_d = k_q - 2'd1;
                        end
                    end else begin
                        level_cnt_d = level_cnt_q + LVL_W'(1);
                    end
                end
                if (wrap_c && time_left_q == 7'd1) begin
                    state_d = S_OVER;
                end else if (stop_flag) begin
                    state_d = S_LANDED;
                    if (lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                    end
                end
            end
            S_LANDED: begin
                state_d = (lives_q != 2'd0) ? S_ARMED : S_OVER;
            end
            S_OVER: begin
                if (start_pe_c) begin
                    init_c  = 1'b1;
                    state_d = S_ARMED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // New game: restore round values before serving.
        if (init_c) begin
            score_d     = '0;
            lives_d     = LIVES_INIT;
            time_left_d = ROUND_SEC;
            k_d         = K_INIT;
            level_cnt_d = '0;
            sec_div_d   = '0;
            arm_cnt_d   = '0;
        end

        release_n_d = !(state_d == S_IDLE || state_d == S_ARMED);
        over_flag_d = (state_d == S_OVER);
        end_beep_d  = (state_d == S_OVER) && (state_q != S_OVER);
    end

    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            release_n_q <= 1'b0;
            k_q         <= K_INIT;
            over_flag_q <= 1'b0;
            end_beep_q  <= 1'b0;
            score_q     <= '0;
            lives_q     <= LIVES_INIT;
            time_left_q <= ROUND_SEC;
            sec_div_q   <= '0;
            level_cnt_q <= '0;
            arm_cnt_q   <= '0;
            btn_q       <= 1'b0;
            above_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            release_n_q <= release_n_d;
            k_q         <= k_d;
            over_flag_q <= over_flag_d;
            end_beep_q  <= end_beep_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            time_left_q <= time_left_d;
            sec_div_q   <= sec_div_d;
            level_cnt_q <= level_cnt_d;
            arm_cnt_q   <= arm_cnt_d;
            btn_q       <= btn_d;
            above_q     <= above_d;
        end
    end

    assign release_n = release_n_q;
    assign home      = HOME_Y;
    assign k         = k_q;
    assign over_flag = over_flag_q;
    assign end_beep  = end_beep_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign time_left = time_left_q;
    assign state     = state_q;

endmodule

// File: tb/tb_ball_game_sequencer.sv
// Directed bench for ball_game_sequencer: serve timing, scoring/levels, lives,
// round timer expiry, restart and asynchronous reset.
module tb_ball_game_sequencer;

    logic        clk_out = 1'b0;
    logic        reset;
    logic        start_btn;
    logic        stop_flag;
    logic [8:0]  pic_y;
    logic [8:0]  handline;
    logic        release_n;
    logic [8:0]  home;
    logic [1:0]  k;
    logic        over_flag;
    logic        end_beep;
    logic [13:0] score;
    logic [1:0]  lives;
    logic [6:0]  time_left;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    ball_game_sequencer dut (
        .clk_out   (clk_out),
        .reset     (reset),
        .start_btn (start_btn),
        .stop_flag (stop_flag),
        .pic_y     (pic_y),
        .handline  (handline),
        .release_n (release_n),
        .home      (home),
        .k         (k),
        .over_flag (over_flag),
        .end_beep  (end_beep),
        .score     (score),
        .lives     (lives),
        .time_left (time_left),
        .state     (state)
    );

    always #5 clk_out = ~clk_out;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    // Ball rises above the hand, then drops back below it.
    task automatic hit_once();
        pic_y = 9'd100;
        tick();
        pic_y = 9'd200;
        tick();
    endtask

    // Called right after the edge that entered ARMED; ends one tick into PLAY.
    task automatic check_serve(input string tag);
        for (int i = 0; i < 3; i++) begin
            check_eq({tag, "_arm_state"}, 32'(state), 32'd1);
            check_eq({tag, "_arm_rel"}, 32'(release_n), 32'd0);
            tick();
        end
        check_eq({tag, "_play_state"}, 32'(state), 32'd2);
        check_eq({tag, "_play_rel"}, 32'(release_n), 32'd1);
    endtask

    initial begin
        reset     = 1'b0;
        start_btn = 1'b0;
        stop_flag = 1'b0;
        pic_y     = 9'd200;
        handline  = 9'd150;
        tick();
        tick();

        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_rel", 32'(release_n), 32'd0);
        check_eq("rst_k", 32'(k), 32'd3);
        check_eq("rst_score", 32'(score), 32'd0);
        check_eq("rst_lives", 32'(lives), 32'd3);
        check_eq("rst_time", 32'(time_left), 32'd60);
        check_eq("rst_over", 32'(over_flag), 32'd0);
        check_eq("rst_beep", 32'(end_beep), 32'd0);
        check_eq("home", 32'(home), 32'd20);

        reset = 1'b1;
        tick();
        check_eq("idle_hold", 32'(state), 32'd0);

        // Start pulse, serve, first PLAY tick.
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check_serve("g1");
        check_eq("g1_time", 32'(time_left), 32'd60);
        check_eq("g1_lives", 32'(lives), 32'd3);
        check_eq("g1_k", 32'(k), 32'd3);

        // Start held high through PLAY must be ignored.
        start_btn = 1'b1;
        for (int i = 0; i < 10; i++) hit_once();
        check_eq("hits10_score", 32'(score), 32'd10);
        check_eq("hits10_k", 32'(k), 32'd2);
        check_eq("hits10_state", 32'(state), 32'd2);
        for (int i = 0; i < 30; i++) hit_once();
        check_eq("hits40_score", 32'(score), 32'd40);
        check_eq("hits40_k", 32'(k), 32'd0);
        for (int i = 0; i < 10; i++) hit_once();
        check_eq("hits50_score", 32'(score), 32'd50);
        check_eq("hits50_k_floor", 32'(k), 32'd0);
        check_eq("hits50_state", 32'(state), 32'd2);
        // 100 PLAY ticks elapsed: one second wrap at tick 55.
        check_eq("hits50_time", 32'(time_left), 32'd59);
        start_btn = 1'b0;

        // Three ball losses.
        for (int n = 0; n < 2; n++) begin
            stop_flag = 1'b1;
            tick();
            stop_flag = 1'b0;
            check_eq("land_state", 32'(state), 32'd3);
            check_eq("land_lives", 32'(lives), 32'(2 - n));
            check_eq("land_rel", 32'(release_n), 32'd1);
            tick();
            check_serve("reserve");
        end
        stop_flag = 1'b1;
        tick();
        stop_flag = 1'b0;
        check_eq("land3_lives", 32'(lives), 32'd0);
        check_eq("land3_state", 32'(state), 32'd3);
        tick();
        check_eq("over_state", 32'(state), 32'd4);
        check_eq("over_flag", 32'(over_flag), 32'd1);
        check_eq("over_beep1", 32'(end_beep), 32'd1);
        check_eq("over_rel", 32'(release_n), 32'd1);
        tick();
        check_eq("over_beep2", 32'(end_beep), 32'd0);
        check_eq("over_flag2", 32'(over_flag), 32'd1);
        tick();
        check_eq("over_score_frozen", 32'(score), 32'd50);
        check_eq("over_state2", 32'(state), 32'd4);

        // Restart from OVER.
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check_eq("rs_score", 32'(score), 32'd0);
        check_eq("rs_over", 32'(over_flag), 32'd0);
        check_eq("rs_lives", 32'(lives), 32'd3);
        check_eq("rs_time", 32'(time_left), 32'd60);
        check_eq("rs_k", 32'(k), 32'd3);
        check_serve("g2");

        // Timer expiry: tick 3300 of PLAY, with stop_flag on the same tick.
        repeat (3299) tick();
        check_eq("t3299_time", 32'(time_left), 32'd1);
        check_eq("t3299_state", 32'(state), 32'd2);
        stop_flag = 1'b1;
        tick();
        stop_flag = 1'b0;
        check_eq("t3300_state", 32'(state), 32'd4);
        check_eq("t3300_time", 32'(time_left), 32'd0);
        check_eq("t3300_lives", 32'(lives), 32'd3);
        check_eq("t3300_beep", 32'(end_beep), 32'd1);

        // Third game, score 7, then asynchronous reset between edges.
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check_serve("g3");
        for (int i = 0; i < 7; i++) hit_once();
        check_eq("g3_score", 32'(score), 32'd7);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_state", 32'(state), 32'd0);
        check_eq("arst_rel", 32'(release_n), 32'd0);
        check_eq("arst_score", 32'(score), 32'd0);
        check_eq("arst_lives", 32'(lives), 32'd3);
        check_eq("arst_time", 32'(time_left), 32'd60);
        check_eq("arst_k", 32'(k), 32'd3);
        check_eq("arst_over", 32'(over_flag), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
